game_controller: RTL and testbench

Top-level game sequencer: the other end of the bird physics interface. It turns raw flap/pause keys into one-cycle `flap` pulses, owns the one-hot `game_state` that bird physics consumes, and closes the loop by checking the returned `birdY` against the screen bounds and the current pipe for collisions. It also keeps the BCD score that the renderer draws. It sits between the key inputs, bird physics, the pipe generator and the video renderer, and is clocked by the frame-rate `GAME_clk`.

---
 rtl/game_pkg.sv | 39 +++
 rtl/game_controller_if.sv | 30 +++
 rtl/game_controller_key_press_detect.sv | 36 +++
 rtl/game_controller.sv | 187 ++++++++++++++++++
 tb/tb_game_controller.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: one-hot game states (also consumed by bird physics
// and the renderer), screen height and BCD score helpers.
package game_pkg;

    typedef enum logic [3:0] {
        START_SCREEN = 4'b0001,
        IN_GAME      = 4'b0010,
        PAUSE        = 4'b0100,
        END_SCREEN   = 4'b1000
    } game_state_t;

    localparam int SCREEN_H     = 480;
    localparam int BCD_DIGIT_W  = 4;
    localparam int SCORE_DIGITS = 3;
    localparam int SCORE_W      = BCD_DIGIT_W * SCORE_DIGITS;

    // Three-digit BCD increment with per-digit carry, saturating at 999.
    function automatic logic [SCORE_W-1:0] bcd_inc_sat(input logic [SCORE_W-1:0] value);
        logic [SCORE_W-1:0] result;
        logic               carry;
        result = value;
        carry  = 1'b1;
        if (value == 12'h999) begin
            return value;
        end
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (carry) begin
                if (value[d*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
                    result[d*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
                end else begin
                    result[d*BCD_DIGIT_W +: BCD_DIGIT_W] = value[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/game_controller_if.sv
// Link between the game controller and bird physics / pipe generator:
// bird and pipe positions come in, flap requests and the game state go out.
interface game_controller_if;
    import game_pkg::*;

    logic [15:0] birdY;
    logic [15:0] pipe_x;
    logic [15:0] gap_y;
    logic        flap;
    game_state_t game_state;

    // Controller side
    modport master (
        input  birdY,
        input  pipe_x,
        input  gap_y,
        output flap,
        output game_state
    );

    // Physics / pipe side
    modport slave (
        output birdY,
        output pipe_x,
        output gap_y,
        input  flap,
        input  game_state
    );

endinterface

// File: rtl/game_controller_key_press_detect.sv
// Active-low key: 2-FF synchronizer followed by a falling-edge detector that
// yields a single-cycle press pulse however long the key is held.
module key_press_detect (
    input  logic GAME_clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       prev_reg;
    logic [1:0] arm_cnt_reg;

    // Synchronize the key and remember last cycle's synchronized level.
    // The arm counter keeps the detector quiet until the synchronizer has
    // flushed its reset value, so a key held through reset gives no press.
    always_ff @(posedge GAME_clk or negedge rst) begin
        if (!rst) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            prev_reg    <= 1'b1;
            arm_cnt_reg <= 2'd0;
        end else begin
            sync1_reg <= key;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (arm_cnt_reg != 2'd3) begin
                arm_cnt_reg <= arm_cnt_reg + 2'd1;
            end
        end
    end

    assign press = prev_reg & ~sync2_reg & (arm_cnt_reg == 2'd3);

endmodule

// File: rtl/game_controller.sv
// Game sequencer: key press detection, one-hot game FSM, collision check of
// the bird against screen bounds and the current pipe, and the BCD score.
// Optional feature macro: GAME_CONTROLLER_HIGH_SCORE_EN adds the high_score
// port and register.
module game_controller
    import game_pkg::*;
#(
    parameter int BIRD_SIZE_X = 34,
    parameter int BIRD_SIZE_Y = 24,
    parameter int BIRD_X      = 200,
    parameter int PIPE_WIDTH  = 52,
    parameter int GAP_SIZE    = 120,
    parameter int END_HOLD    = 60
) (
    input  logic                GAME_clk,
    input  logic                rst,
    input  logic                flap_key,
    input  logic                pause_key,
    game_controller_if.master   bus,
    output logic [SCORE_W-1:0]  score
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    ,
    output logic [SCORE_W-1:0]  high_score
`endif
);

    localparam logic [16:0] BIRD_X_W      = 17'(BIRD_X);
    localparam logic [16:0] BIRD_SIZE_X_W = 17'(BIRD_SIZE_X);
    localparam logic [16:0] BIRD_SIZE_Y_W = 17'(BIRD_SIZE_Y);
    localparam logic [16:0] PIPE_WIDTH_W  = 17'(PIPE_WIDTH);
    localparam logic [16:0] GAP_SIZE_W    = 17'(GAP_SIZE);
    localparam logic [16:0] SCREEN_H_W    = 17'(SCREEN_H);
    localparam logic [15:0] END_HOLD_W    = 16'(END_HOLD);

    // ---------------- key inputs: index 0 = flap, 1 = pause ----------------
    logic [1:0] key_raw;
    logic [1:0] key_press;
    logic       flap_press;
    logic       pause_press;

    assign key_raw = {pause_key, flap_key};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_press_detect u_key (
                .GAME_clk (GAME_clk),
                .rst      (rst),
                .key      (key_raw[gi]),
                .press    (key_press[gi])
            );
        end
    endgenerate

    assign flap_press  = key_press[0];
    assign pause_press = key_press[1];

    // ---------------- collision (all sums 17-bit, no wrap) ----------------
    logic [16:0] bird_top;
    logic [16:0] bird_bot;
    logic [16:0] pipe_left;
    logic [16:0] pipe_edge;
    logic [16:0] gap_top;
    logic [16:0] gap_bot;
    logic        out_of_bounds;
    logic        x_overlap;
    logic        outside_gap;
    logic        collision;

    assign bird_top  = {1'b0, bus.birdY};
    assign bird_bot  = bird_top + BIRD_SIZE_Y_W;
    assign pipe_left = {1'b0, bus.pipe_x};
    assign pipe_edge = pipe_left + PIPE_WIDTH_W;
    assign gap_top   = {1'b0, bus.gap_y};
    assign gap_bot   = gap_top + GAP_SIZE_W;

    assign out_of_bounds = bus.birdY[15] | (bird_bot > SCREEN_H_W);
    assign x_overlap     = (BIRD_X_W < pipe_edge) && (pipe_left < (BIRD_X_W + BIRD_SIZE_X_W));
    assign outside_gap   = (bird_top < gap_top) || (bird_bot > gap_bot);
    assign collision     = out_of_bounds || (x_overlap && outside_gap);

    // ---------------- state ----------------
    game_state_t        state_reg, state_next;
    logic               flap_reg, flap_next;
    logic [SCORE_W-1:0] score_reg;
    logic [16:0]        prev_edge_reg;
    logic [15:0]        hold_reg;
    logic               clear_score;
    logic               enter_end;
    logic               score_inc;

    // Next-state and flap pulse; collision outranks pause, pause outranks flap.
    always_comb begin
        state_next  = state_reg;
        flap_next   = 1'b0;
        clear_score = 1'b0;
        enter_end   = 1'b0;
        case (state_reg)
            START_SCREEN: begin
                if (flap_press) begin
                    state_next  = IN_GAME;
                    flap_next   = 1'b1;
                    clear_score = 1'b1;
                end
            end
            IN_GAME: begin
                if (collision) begin
                    state_next = END_SCREEN;
                    enter_end  = 1'b1;
                end else if (pause_press) begin
                    state_next = PAUSE;
                end else if (flap_press) begin
                    flap_next = 1'b1;
                end
            end
            PAUSE: begin
                if (pause_press) begin
                    state_next = IN_GAME;
                end
            end
            END_SCREEN: begin
                if ((hold_reg == 16'd0) && flap_press) begin
                    state_next = START_SCREEN;
                end
            end
            default: begin
                state_next = START_SCREEN;
            end
        endcase
    end

    // A pipe is passed when its right edge crosses from >= BIRD_X to < BIRD_X;
    // a respawn jumps the edge upward and therefore never counts.
    assign score_inc = (state_reg == IN_GAME) && !collision &&
                       (prev_edge_reg >= BIRD_X_W) && (pipe_edge < BIRD_X_W);

    // FSM state register and the registered flap pulse.
    always_ff @(posedge GAME_clk or negedge rst) begin
        if (!rst) begin
            state_reg <= START_SCREEN;
            flap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            flap_reg  <= flap_next;
        end
    end

    // Score, previous pipe edge and the END_SCREEN hold counter.
    always_ff @(posedge GAME_clk or negedge rst) begin
        if (!rst) begin
            score_reg     <= '0;
            prev_edge_reg <= '0;
            hold_reg      <= '0;
        end else begin
            prev_edge_reg <= pipe_edge;
            if (clear_score) begin
                score_reg <= '0;
            end else if (score_inc) begin
                score_reg <= bcd_inc_sat(score_reg);
            end
            if (enter_end) begin
                hold_reg <= END_HOLD_W;
            end else if ((state_reg == END_SCREEN) && (hold_reg != 16'd0)) begin
                hold_reg <= hold_reg - 16'd1;
            end
        end
    end

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_reg;

    // Best score is captured when a game ends; BCD orders like binary.
    always_ff @(posedge GAME_clk or negedge rst) begin
        if (!rst) begin
            high_score_reg <= '0;
        end else if (enter_end && (score_reg > high_score_reg)) begin
            high_score_reg <= score_reg;
        end
    end

    assign high_score = high_score_reg;
`endif

    assign bus.flap       = flap_reg;
    assign bus.game_state = state_reg;
    assign score          = score_reg;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: key latency, collisions, scoring,
// pause, END_SCREEN hold, reset behaviour and (when enabled) high score.
module tb_game_controller;
    import game_pkg::*;

    logic        GAME_clk = 1'b0;
    logic        rst = 1'b0;
    logic        flap_key = 1'b1;
    logic        pause_key = 1'b1;
    logic [11:0] score;
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    logic [11:0] high_score;
`endif

    game_controller_if bus ();

    game_controller dut (
        .GAME_clk   (GAME_clk),
        .rst        (rst),
        .flap_key   (flap_key),
        .pause_key  (pause_key),
        .bus        (bus),
        .score      (score)
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
        ,
        .high_score (high_score)
`endif
    );

    always #5 GAME_clk = ~GAME_clk;

    int   total = 0;
    int   bad = 0;
    logic flap_seen;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic cyc();
        @(posedge GAME_clk);
        @(negedge GAME_clk);
    endtask

    // Hold a key low for 3 cycles (press lands on the third edge), release,
    // then let 2 more cycles pass; records whether flap was ever seen high.
    task automatic press(input bit use_pause);
        flap_seen = 1'b0;
        if (use_pause) pause_key = 1'b0;
        else           flap_key  = 1'b0;
        repeat (3) begin
            cyc();
            flap_seen = flap_seen | bus.flap;
        end
        flap_key  = 1'b1;
        pause_key = 1'b1;
        repeat (2) begin
            cyc();
            flap_seen = flap_seen | bus.flap;
        end
    endtask

    task automatic pass_pipe();
        bus.pipe_x = 16'd150; cyc();
        bus.pipe_x = 16'd145; cyc();
        bus.pipe_x = 16'd600; cyc();
    endtask

    task automatic end_to_start();
        repeat (62) cyc();
        press(1'b0);
        check("end->start", 32'(bus.game_state), 32'h1);
    endtask

    task automatic start_game();
        press(1'b0);
        check("start->game", 32'(bus.game_state), 32'h2);
        check("start flap pulse", 32'(flap_seen), 32'h1);
        check("score cleared", 32'(score), 32'h000);
    endtask

    // Play n pipe passes then crash into the upper pipe.
    task automatic play(input int n, input logic [11:0] exp_bcd);
        repeat (n) pass_pipe();
        bus.birdY  = 16'd40;
        bus.pipe_x = 16'd150;
        cyc();
        check("pipe hit -> end", 32'(bus.game_state), 32'h8);
        check("game score", 32'(score), 32'(exp_bcd));
        bus.birdY  = 16'd100;
        bus.pipe_x = 16'd600;
    endtask

    initial begin
        bus.birdY  = 16'd100;
        bus.pipe_x = 16'd600;
        bus.gap_y  = 16'd50;

        // Reset state
        repeat (3) cyc();
        check("reset state", 32'(bus.game_state), 32'h1);
        check("reset flap", 32'(bus.flap), 32'h0);
        check("reset score", 32'(score), 32'h000);
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
        check("reset high", 32'(high_score), 32'h000);
`endif
        rst = 1'b1;
        repeat (4) cyc();

        // Flap key held 5 cycles: one pulse at N+2
        flap_key = 1'b0;
        cyc(); check("flap N", 32'(bus.flap), 32'h0);
        cyc(); check("flap N+1", 32'(bus.flap), 32'h0);
        check("state N+1", 32'(bus.game_state), 32'h1);
        cyc(); check("flap N+2", 32'(bus.flap), 32'h1);
        check("state N+2", 32'(bus.game_state), 32'h2);
        cyc(); check("flap N+3", 32'(bus.flap), 32'h0);
        cyc(); cyc(); check("flap held", 32'(bus.flap), 32'h0);
        flap_key = 1'b1;
        repeat (2) cyc();

        // Bottom boundary: 456+24 = 480 is still on screen
        bus.birdY = 16'd456; cyc();
        check("bottom 480 ok", 32'(bus.game_state), 32'h2);
        // Negative birdY
        bus.birdY = 16'hFFFE; cyc();
        check("negative y end", 32'(bus.game_state), 32'h8);
        bus.birdY = 16'd100;
        end_to_start();
        start_game();

        // 460+24 = 484 > 480
        bus.birdY = 16'd460; cyc();
        check("bottom 484 end", 32'(bus.game_state), 32'h8);
        bus.birdY = 16'd100;
        end_to_start();
        start_game();

        // Score on pass, not on respawn
        bus.pipe_x = 16'd150; cyc();
        check("edge 202 no inc", 32'(score), 32'h000);
        bus.pipe_x = 16'd145; cyc();
        check("edge 197 inc", 32'(score), 32'h001);
        bus.pipe_x = 16'd10;  cyc();
        bus.pipe_x = 16'd600; cyc();
        check("respawn no inc", 32'(score), 32'h001);

        // Pause: score held, flap discarded, resume
        press(1'b1);
        check("pause", 32'(bus.game_state), 32'h4);
        pass_pipe();
        check("pause holds score", 32'(score), 32'h001);
        press(1'b0);
        check("pause flap no pulse", 32'(flap_seen), 32'h0);
        check("pause stays", 32'(bus.game_state), 32'h4);
        press(1'b1);
        check("resume", 32'(bus.game_state), 32'h2);
        pass_pipe();
        check("resume score", 32'(score), 32'h002);

        // BCD carry and saturation
        repeat (97) pass_pipe();
        check("score 099", 32'(score), 32'h099);
        pass_pipe();
        check("score 100", 32'(score), 32'h100);
        repeat (899) pass_pipe();
        check("score 999", 32'(score), 32'h999);
        pass_pipe();
        check("score sat", 32'(score), 32'h999);

        // Collision and pause press in the same cycle
        pause_key = 1'b0;
        cyc(); cyc();
        bus.birdY = 16'hFFFE;
        cyc();
        check("collide beats pause", 32'(bus.game_state), 32'h8);
        pause_key = 1'b1;
        bus.birdY = 16'd100;
        cyc(); cyc();
        check("end no pause", 32'(bus.game_state), 32'h8);

        // Hold period ignores flap, then flap returns to START
        repeat (25) cyc();
        press(1'b0);
        check("hold ignores flap", 32'(bus.game_state), 32'h8);
        end_to_start();

        // Flap and pause together in START: flap wins
        flap_key = 1'b0; pause_key = 1'b0;
        cyc(); cyc(); cyc();
        check("both keys state", 32'(bus.game_state), 32'h2);
        check("both keys flap", 32'(bus.flap), 32'h1);
        flap_key = 1'b1; pause_key = 1'b1;
        cyc(); cyc();
        check("both keys no pause", 32'(bus.game_state), 32'h2);

        // Reset mid-game
        pass_pipe(); pass_pipe();
        check("pre-reset score", 32'(score), 32'h002);
        rst = 1'b0;
        #1;
        check("mid reset state", 32'(bus.game_state), 32'h1);
        check("mid reset score", 32'(score), 32'h000);
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
        check("mid reset high", 32'(high_score), 32'h000);
`endif
        // Key held through reset release: no press
        flap_key = 1'b0;
        cyc();
        rst = 1'b1;
        flap_seen = 1'b0;
        repeat (6) begin
            cyc();
            flap_seen = flap_seen | bus.flap;
        end
        check("held key no flap", 32'(flap_seen), 32'h0);
        check("held key state", 32'(bus.game_state), 32'h1);
        flap_key = 1'b1;
        repeat (3) cyc();

        // Three games: 5, 3, 7
        start_game();
        play(5, 12'h005);
        end_to_start();
        start_game();
        play(3, 12'h003);
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
        check("high after 3", 32'(high_score), 32'h005);
`endif
        end_to_start();
        start_game();
        play(7, 12'h007);
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
        check("high score", 32'(high_score), 32'h007);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
